// File: rtl/uart_frame_loader_pkg.sv
// Shared types and constants for the UART frame loader: FSM states, error codes
// and the default frame start marker.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_CSUM    = 2'd1;
  localparam err_code_t ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // States in which a byte from the receiver may be taken.
  function automatic logic accepts_bytes(input state_t s);
    return (s == IDLE) || (s == ADDR) || (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

  // States in which the inter-byte timeout runs.
  function automatic logic timed_state(input state_t s);
    return (s == ADDR) || (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Byte-stream input and memory write port of the frame loader.
// slave is the loader's view, master is the UART/memory side.
interface uart_frame_loader_if #(
  parameter int ADDR_W = 32
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport slave (
    input  in_data, in_valid, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_data, in_valid, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_frame_loader_timeout.sv
// Inter-byte watchdog: down-counter reloaded on clr, decremented while en,
// expire flags terminal count while enabled.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else if (clr) begin
      cnt_q <= LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/uart_frame_loader.sv
// Parses sync/address/count/payload/checksum load frames from the UART byte
// stream and streams 32-bit word writes to memory.
//
//   state | meaning
//   IDLE  | hunting for SYNC_BYTE, other bytes dropped
//   ADDR  | 4 little-endian start address bytes
//   LEN   | 2 little-endian word count bytes
//   DATA  | 4 little-endian payload bytes of the next word
//   WRITE | word presented on memory port until mem_ready
//   CSUM  | checksum byte
//   DONE  | one-cycle success pulse
//   ERR   | one-cycle failure pulse (checksum or timeout)
module uart_frame_loader
  import uart_loader_pkg::*;
#(
  parameter int          ADDR_W         = 32,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_frame_loader_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  state_t            state_q;
  state_t            state_nxt;
  logic              in_ready_q;
  logic              accept;
  logic [31:0]       sh_q;
  logic [31:0]       asm_word;
  logic [1:0]        idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       remain_q;
  logic [7:0]        sum_q;
  logic [7:0]        sum_nxt;
  err_code_t         err_code_q;
  logic              to_en;
  logic              expire;
  logic              write_done;

  assign accept     = bus.in_valid && in_ready_q;
  assign asm_word   = {bus.in_data, sh_q[31:8]};
  assign sum_nxt    = sum_q + bus.in_data;
  assign to_en      = timed_state(state_q);
  assign write_done = (state_q == WRITE) && bus.mem_ready;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (to_en),
    .expire (expire)
  );

  // in_ready is registered from the next state so it is low during reset
  // and high in the first cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      in_ready_q <= accepts_bytes(state_nxt);
    end
  end

  // An accepted byte always takes priority over a timeout in the same cycle.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (bus.in_data == SYNC_BYTE)) state_nxt = ADDR;
      end
      ADDR: begin
        if (accept) begin
          if (idx_q == 2'd3) state_nxt = LEN;
        end else if (expire) begin
          state_nxt = ERR;
        end
      end
      LEN: begin
        if (accept) begin
          if (idx_q == 2'd1) state_nxt = (asm_word[31:16] == 16'd0) ? CSUM : DATA;
        end else if (expire) begin
          state_nxt = ERR;
        end
      end
      DATA: begin
        if (accept) begin
          if (idx_q == 2'd3) state_nxt = WRITE;
        end else if (expire) begin
          state_nxt = ERR;
        end
      end
      WRITE: begin
        if (bus.mem_ready) state_nxt = (remain_q == 16'd1) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept) begin
          state_nxt = (sum_nxt == 8'd0) ? DONE : ERR;
        end else if (expire) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == ADDR) || (state_q == LEN) || (state_q == DATA) ||
                 (state_q == WRITE) || (state_q == CSUM);
    done       = (state_q == DONE);
    err        = (state_q == ERR);
    bus.mem_we = (state_q == WRITE);
  end

  // One byte shifter serves address, count and payload assembly; it holds the
  // finished word untouched while WRITE waits on memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      sum_q      <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      if (accept) begin
        sh_q <= asm_word;
        unique case (state_q)
          IDLE: begin
            if (bus.in_data == SYNC_BYTE) begin
              sum_q      <= '0;
              idx_q      <= '0;
              err_code_q <= ERR_NONE;
            end
          end
          ADDR: begin
            sum_q <= sum_nxt;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) addr_q <= ADDR_W'(asm_word) & ~ADDR_W'(3);
          end
          LEN: begin
            sum_q <= sum_nxt;
            if (idx_q == 2'd1) begin
              idx_q    <= '0;
              remain_q <= asm_word[31:16];
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
          DATA: begin
            sum_q <= sum_nxt;
            idx_q <= idx_q + 2'd1;
          end
          CSUM: begin
            if (sum_nxt != 8'd0) err_code_q <= ERR_CSUM;
          end
          default: ;
        endcase
      end else if (expire) begin
        err_code_q <= ERR_TIMEOUT;
      end

      if (write_done) begin
        addr_q   <= addr_q + ADDR_W'(4);
        remain_q <= remain_q - 16'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = sh_q;
  assign err_code      = err_code_q;

endmodule
